// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver: FSM states,
// segment bit positions and the hex glyph table.
package seg7_scan_driver_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Segment vector layout is {dp,g,f,e,d,c,b,a}
  localparam int unsigned SEG_DP_BIT = 7;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Valid/ready load port carrying the packed hex nibbles for all digits.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to a..g segment pattern (active-high).
module seg7_scan_driver_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] pattern_o
);
  always_comb pattern_o = HEX_SEG[nibble_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver with double-buffered load port and guard slots.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  seg7_scan_driver_if.slave   load_if,
  input  logic [DIGITS-1:0]   dp_in_i,
  input  logic [DIGITS-1:0]   blank_mask_i,
  output logic [7:0]          seg_o,
  output logic [DIGITS-1:0]   dig_en_o,
  output logic                frame_start_o
);

  localparam int unsigned IW = clog2_min1(DIGITS);
  localparam int unsigned CW = clog2_min1((PRESCALE > GUARD_CYCLES) ? PRESCALE : GUARD_CYCLES);
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [4*DIGITS-1:0]   shad_q, shad_d;
  logic                  full_q, full_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  fs_q, fs_d;

  logic                  frame_entry;
  logic [3:0]            nibble;
  logic [6:0]            pattern;
  logic [DIGITS-1:0]     lz_blank;
  logic [7:0]            seg_on;
  logic [DIGITS-1:0]     dig_on;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    if (!enable_i) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_GUARD;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_GUARD: begin
          if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CW'(PRESCALE - 1)) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
    frame_entry = (state_d == ST_GUARD) && (state_q != ST_GUARD) && (idx_d == '0);
  end

  // Commit uses full_q, so data captured on a boundary edge waits for the next boundary
  always_comb begin
    disp_d = disp_q;
    shad_d = shad_q;
    full_d = full_q;
    if (full_q && ((state_q == ST_OFF) || frame_entry)) begin
      disp_d = shad_q;
      full_d = 1'b0;
    end
    if (load_if.load_valid && !full_q) begin
      shad_d = load_if.load_data;
      full_d = 1'b1;
    end
  end

  assign load_if.load_ready = !full_q;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int unsigned k = DIGITS; k > 1; k--) begin
      zero_run      = zero_run && (disp_q[4*(k-1) +: 4] == 4'h0);
      lz_blank[k-1] = zero_run;
    end
  end
`else
  always_comb lz_blank = '0;
`endif

  always_comb nibble = disp_q[{idx_q, 2'b00} +: 4];

  seg7_scan_driver_hex_decode u_decode (
    .nibble_i  (nibble),
    .pattern_o (pattern)
  );

  always_comb begin
    seg_on = {1'b0, pattern};
    seg_on[SEG_DP_BIT] = dp_in_i[idx_q];
    if (blank_mask_i[idx_q] || lz_blank[idx_q]) seg_on = '0;
    dig_on = '0;
    dig_on[idx_q] = 1'b1;
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    // Dropping enable darkens the pins on the same edge the FSM goes OFF
    if (enable_i && (state_q == ST_DRIVE)) begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
      dig_d = DIG_ACTIVE_LOW ? ~dig_on : dig_on;
    end
    fs_d = frame_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      shad_q  <= '0;
      full_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      shad_q  <= shad_d;
      full_q  <= full_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      fs_q    <= fs_d;
    end
  end

  assign seg_o         = seg_q;
  assign dig_en_o      = dig_q;
  assign frame_start_o = fs_q;

endmodule
